drv_teclado_4x4: RTL and testbench

//   Scanner for a 4x4 matrix keypad. Drives one column at a time, one-hot and active-high.

---
 rtl/drv_teclado_pkg.sv | 45 ++++
 rtl/drv_teclado_4x4_col_scan.sv | 35 +++
 rtl/drv_teclado_4x4.sv | 78 +++++++
 tb/tb_drv_teclado_4x4.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/drv_teclado_pkg.sv
// Shared keypad definitions: geometry, key-code constants and the row/column -> code map.
package drv_teclado_pkg;

  localparam int COLS = 4;
  localparam int ROWS = 4;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic { ARMED, WAIT_REL } arm_state_t;

  // Lowest active row wins when several rows are asserted together.
  function automatic logic [1:0] low_row(input logic [ROWS-1:0] f);
    low_row = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (f[i]) low_row = 2'(i);
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    keymap = 4'd0;
    case ({row, col})
      4'b00_00: keymap = 4'd1;
      4'b00_01: keymap = 4'd2;
      4'b00_10: keymap = 4'd3;
      4'b00_11: keymap = KEY_A;
      4'b01_00: keymap = 4'd4;
      4'b01_01: keymap = 4'd5;
      4'b01_10: keymap = 4'd6;
      4'b01_11: keymap = KEY_B;
      4'b10_00: keymap = 4'd7;
      4'b10_01: keymap = 4'd8;
      4'b10_10: keymap = 4'd9;
      4'b10_11: keymap = KEY_C;
      4'b11_00: keymap = KEY_STAR;
      4'b11_01: keymap = 4'd0;
      4'b11_10: keymap = KEY_HASH;
      default:  keymap = KEY_D;
    endcase
  endfunction

endpackage

// File: rtl/drv_teclado_4x4_col_scan.sv
// Column scanner: clock divider plus a one-hot ring that advances one column per tick.
// Runs continuously; tick marks the last cycle of each column slot.
module teclado_col_scan
  import drv_teclado_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic [COLS-1:0] col,
  output logic [1:0]      col_idx,
  output logic            tick
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div     <= '0;
      col     <= 4'b0001;
      col_idx <= 2'd0;
    end else if (tick) begin
      div     <= '0;
      col     <= {col[COLS-2:0], col[COLS-1]};
      col_idx <= col_idx + 2'd1;
    end else begin
      div     <= div + DW'(1);
    end
  end

endmodule

// File: rtl/drv_teclado_4x4.sv
// 4x4 keypad driver: scans columns, decodes one press per key-down into a code and display slot.
// A held key produces a single strobe; re-arming needs four consecutive idle tick samples.
module drv_teclado_4x4
  import drv_teclado_pkg::*;
#(
  parameter int SCAN_DIV = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] fila,
  output logic [COLS-1:0] col,
  output logic [4:0]      digito,
  output logic [1:0]      desp
);

  logic [1:0]  col_idx;
  logic        tick;
  arm_state_t  state, state_n;
  logic [1:0]  pos, pos_n;
  logic [1:0]  zero_cnt, zero_n;   // reaching 4 is the re-arm point, so 2 bits suffice
  logic [4:0]  digito_n;
  logic [1:0]  desp_n;

  teclado_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk     (clk),
    .rst     (rst),
    .col     (col),
    .col_idx (col_idx),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARMED;
      pos      <= 2'd0;
      zero_cnt <= 2'd0;
      digito   <= 5'b0_0000;
      desp     <= 2'd0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      zero_cnt <= zero_n;
      digito   <= digito_n;
      desp     <= desp_n;
    end
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    zero_n   = zero_cnt;
    digito_n = {1'b0, digito[3:0]};
    desp_n   = desp;
    case (state)
      ARMED: begin
        if (fila != '0) begin
          digito_n = {1'b1, keymap(low_row(fila), col_idx)};
          desp_n   = pos;
          pos_n    = pos + 2'd1;
          state_n  = WAIT_REL;
        end
      end
      default: begin
        if (tick) begin
          if (fila != '0) begin
            zero_n = 2'd0;
          end else if (zero_cnt == 2'd3) begin
            zero_n  = 2'd0;
            state_n = ARMED;
          end else begin
            zero_n = zero_cnt + 2'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_drv_teclado_4x4.sv
// Randomized + directed bench for drv_teclado_4x4 against a behavioural keypad model.
module tb_drv_teclado_4x4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] fila = 4'd0;
  logic [3:0] col;
  logic [4:0] digito;
  logic [1:0] desp;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: keypad legend laid out row-major, scan position counted in cycles.
  int keytab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int m_cidx, m_pos, m_desp, m_zc;
  int m_code;
  bit m_strobe, m_armed;
  int strobes;

  drv_teclado_4x4 #(.SCAN_DIV(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .fila   (fila),
    .col    (col),
    .digito (digito),
    .desp   (desp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_cidx = 0; m_pos = 0; m_desp = 0; m_zc = 0;
    m_code = 0; m_strobe = 0; m_armed = 1;
  endtask

  // One clock cycle: apply fila/rst, check outputs mid-cycle, advance model at the edge.
  task automatic cyc(input logic [3:0] f, input logic r);
    int row;
    fila = f;
    rst  = r;
    @(negedge clk);
    chk("col", int'(col), 1 << m_cidx);
    chk("strobe", int'(digito[4]), int'(m_strobe));
    chk("code", int'(digito[3:0]), m_code);
    chk("desp", int'(desp), m_desp);
    if (digito[4]) strobes++;
    if (r) begin
      model_reset();
    end else begin
      m_strobe = 0;
      if (m_armed && f != 0) begin
        row = 0;
        while (!f[row]) row++;
        m_code   = keytab[row * 4 + m_cidx];
        m_strobe = 1;
        m_desp   = m_pos;
        m_pos    = (m_pos + 1) % 4;
        m_armed  = 0;
      end else if (!m_armed) begin
        if (f == 0) begin
          m_zc++;
          if (m_zc == 4) begin
            m_armed = 1;
            m_zc    = 0;
          end
        end else begin
          m_zc = 0;
        end
      end
      m_cidx = (m_cidx + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic press_at(input int cidx, input logic [3:0] f);
    while (m_cidx != cidx) cyc(4'd0, 1'b0);
    cyc(f, 1'b0);
  endtask

  initial begin
    logic [3:0] rf;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    strobes = 0;

    // Idle scan and reset values
    for (int i = 0; i < 6; i++) cyc(4'd0, 1'b0);

    // Row 2 at column 0 -> '7', then row 0 at column 2 -> '3'
    press_at(0, 4'b0100);
    repeat (4) cyc(4'd0, 1'b0);
    press_at(2, 4'b0001);
    repeat (5) cyc(4'd0, 1'b0);

    // Held key: one strobe only
    strobes = 0;
    while (m_cidx != 1) cyc(4'd0, 1'b0);
    repeat (20) cyc(4'b1000, 1'b0);
    cyc(4'd0, 1'b0);
    chk("held_strobes", strobes, 1);
    repeat (4) cyc(4'd0, 1'b0);

    // Four more presses to show position wrap; multi-row press picks the lowest row
    press_at(3, 4'b0110);
    repeat (5) cyc(4'd0, 1'b0);
    press_at(1, 4'b1000);
    repeat (5) cyc(4'd0, 1'b0);
    press_at(0, 4'b1111);
    repeat (5) cyc(4'd0, 1'b0);
    press_at(2, 4'b1000);
    repeat (5) cyc(4'd0, 1'b0);

    // Reset coincident with a press sample drops the strobe
    press_at(3, 4'b0010);
    repeat (5) cyc(4'd0, 1'b0);
    while (m_cidx != 2) cyc(4'd0, 1'b0);
    cyc(4'b0010, 1'b1);
    repeat (3) cyc(4'd0, 1'b0);

    // Random traffic: bursty keys, short glitches, rare resets
    for (int i = 0; i < 600; i++) begin
      rf = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 9))
        0, 1, 2: cyc(rf, 1'b0);
        3:       repeat ($urandom_range(2, 8)) cyc(rf, 1'b0);
        4:       cyc(4'd0, ($urandom_range(0, 15) == 0));
        default: cyc(4'd0, 1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
